// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipelined MIPS control unit: opcodes, bundle
// widths, field positions and ALUOp encodings.
package pipe_ctrl_pkg;

  localparam int unsigned OP_RTYPE = 0;
  localparam int unsigned OP_J     = 2;
  localparam int unsigned OP_BEQ   = 4;
  localparam int unsigned OP_ADDI  = 8;
  localparam int unsigned OP_LW    = 35;
  localparam int unsigned OP_SW    = 43;

  localparam int unsigned EX_W = 4;
  localparam int unsigned M_W  = 3;
  localparam int unsigned WB_W = 2;

  localparam int unsigned EX_REGDST   = 3;
  localparam int unsigned EX_ALUSRC   = 2;
  localparam int unsigned EX_ALUOP_HI = 1;
  localparam int unsigned EX_ALUOP_LO = 0;

  localparam int unsigned M_BRANCH   = 2;
  localparam int unsigned M_MEMREAD  = 1;
  localparam int unsigned M_MEMWRITE = 0;

  localparam int unsigned WB_REGWRITE = 1;
  localparam int unsigned WB_MEMTOREG = 0;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic [EX_W-1:0] ex;
    logic [M_W-1:0]  m;
    logic [WB_W-1:0] wb;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{ex: 4'b0000, m: 3'b000, wb: 2'b00};

endpackage

// File: rtl/pipe_control_unit_decode.sv
// Pure combinational main decoder: opcode in ID to {ex, m, wb} bundles plus
// jump and illegal-opcode flags.
module pipe_ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic                valid_i,
  output ctrl_t               ctrl_o,
  output logic                jump_o,
  output logic                illegal_o
);

  // Decode table; a non-valid slot decodes as a silent bubble.
  always_comb begin
    ctrl_o    = CTRL_NOP;
    jump_o    = 1'b0;
    illegal_o = 1'b0;
    if (valid_i) begin
      case (opcode_i)
        OPCODE_W'(OP_RTYPE): begin
          ctrl_o.ex[EX_REGDST]                = 1'b1;
          ctrl_o.ex[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_FUNCT;
          ctrl_o.wb[WB_REGWRITE]              = 1'b1;
        end
        OPCODE_W'(OP_LW): begin
          ctrl_o.ex[EX_ALUSRC]                = 1'b1;
          ctrl_o.ex[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_ADD;
          ctrl_o.m[M_MEMREAD]                 = 1'b1;
          ctrl_o.wb[WB_REGWRITE]              = 1'b1;
          ctrl_o.wb[WB_MEMTOREG]              = 1'b1;
        end
        OPCODE_W'(OP_SW): begin
          ctrl_o.ex[EX_ALUSRC]                = 1'b1;
          ctrl_o.ex[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_ADD;
          ctrl_o.m[M_MEMWRITE]                = 1'b1;
        end
        OPCODE_W'(OP_BEQ): begin
          // beq never writes the register file.
          ctrl_o.ex[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_SUB;
          ctrl_o.m[M_BRANCH]                  = 1'b1;
        end
        OPCODE_W'(OP_ADDI): begin
          ctrl_o.ex[EX_ALUSRC]                = 1'b1;
          ctrl_o.ex[EX_ALUOP_HI:EX_ALUOP_LO]  = ALUOP_ADD;
          ctrl_o.wb[WB_REGWRITE]              = 1'b1;
        end
        OPCODE_W'(OP_J): begin
          jump_o = 1'b1;
        end
        default: begin
          illegal_o = 1'b1;
        end
      endcase
    end else begin
      ctrl_o = CTRL_NOP;
    end
  end

endmodule

// File: rtl/pipe_control_unit.sv
// Pipelined control unit: decodes in ID and stages control through ID/EX,
// EX/MEM and MEM/WB with load-use stall, flush and saturating event counters.
module pipe_control_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int OPCODE_W  = 6,
  parameter int REG_W     = 5,
  parameter int CNT_W     = 16,
  parameter bit EN_HAZARD = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] id_opcode,
  input  logic                id_valid,
  input  logic [REG_W-1:0]    id_rs,
  input  logic [REG_W-1:0]    id_rt,
  input  logic                flush,
  output logic [EX_W-1:0]     ex_ctrl,
  output logic [M_W-1:0]      mem_ctrl,
  output logic [WB_W-1:0]     wb_ctrl,
  output logic                id_jump,
  output logic                id_illegal,
  output logic                pc_write,
  output logic                ifid_write,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  ctrl_t             dec_s;
  ctrl_t             idex_q, idex_d;
  logic [REG_W-1:0]  idex_rt_q, idex_rt_d;
  logic [M_W-1:0]    exmem_m_q, exmem_m_d;
  logic [WB_W-1:0]   exmem_wb_q, exmem_wb_d;
  logic [WB_W-1:0]   memwb_wb_q, memwb_wb_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              hazard_s;
  logic              stall_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  pipe_ctrl_decode #(
    .OPCODE_W(OPCODE_W)
  ) u_decode (
    .opcode_i (id_opcode),
    .valid_i  (id_valid),
    .ctrl_o   (dec_s),
    .jump_o   (id_jump),
    .illegal_o(id_illegal)
  );

  // A load in EX whose destination feeds the instruction in ID forces one bubble.
  assign hazard_s = EN_HAZARD && idex_q.m[M_MEMREAD] && (idex_rt_q != '0) &&
                    ((idex_rt_q == id_rs) || (idex_rt_q == id_rt));
  assign stall_s    = hazard_s && !flush;
  assign pc_write   = !reset && !stall_s;
  assign ifid_write = !reset && !stall_s;

  // Next-state for the control pipeline and event counters.
  always_comb begin
    idex_d      = CTRL_NOP;
    idex_rt_d   = '0;
    exmem_m_d   = '0;
    exmem_wb_d  = '0;
    memwb_wb_d  = '0;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (reset) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (flush || stall_s) begin
        idex_d    = CTRL_NOP;
        idex_rt_d = '0;
      end else begin
        idex_d    = dec_s;
        idex_rt_d = id_valid ? id_rt : '0;
      end
      if (flush) begin
        exmem_m_d  = '0;
        exmem_wb_d = '0;
      end else begin
        exmem_m_d  = idex_q.m;
        exmem_wb_d = idex_q.wb;
      end
      memwb_wb_d = exmem_wb_q;
      if (stall_s) begin
        stall_cnt_d = sat_inc(stall_cnt_q);
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
      if (flush) begin
        flush_cnt_d = sat_inc(flush_cnt_q);
      end else begin
        flush_cnt_d = flush_cnt_q;
      end
    end
  end

  // Pipeline control registers and counters.
  always_ff @(posedge clk) begin
    idex_q      <= idex_d;
    idex_rt_q   <= idex_rt_d;
    exmem_m_q   <= exmem_m_d;
    exmem_wb_q  <= exmem_wb_d;
    memwb_wb_q  <= memwb_wb_d;
    stall_cnt_q <= stall_cnt_d;
    flush_cnt_q <= flush_cnt_d;
  end

  assign ex_ctrl   = idex_q.ex;
  assign mem_ctrl  = exmem_m_q;
  assign wb_ctrl   = memwb_wb_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed and randomized bench for pipe_control_unit against a slot-shifting
// reference model; a second instance with 2-bit counters checks saturation.
module tb_pipe_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] id_opcode = 6'd0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = 5'd0;
  logic [4:0] id_rt = 5'd0;
  logic       flush = 1'b0;

  logic [3:0]  ex_ctrl, s_ex_ctrl;
  logic [2:0]  mem_ctrl, s_mem_ctrl;
  logic [1:0]  wb_ctrl, s_wb_ctrl;
  logic        id_jump, s_id_jump, id_illegal, s_id_illegal;
  logic        pc_write, s_pc_write, ifid_write, s_ifid_write;
  logic [15:0] stall_cnt, flush_cnt;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  pipe_control_unit #(.OPCODE_W(6), .REG_W(5), .CNT_W(16), .EN_HAZARD(1'b1)) dut (
    .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .flush(flush),
    .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
    .id_jump(id_jump), .id_illegal(id_illegal), .pc_write(pc_write),
    .ifid_write(ifid_write), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_control_unit #(.OPCODE_W(6), .REG_W(5), .CNT_W(2), .EN_HAZARD(1'b1)) dut_small (
    .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .flush(flush),
    .ex_ctrl(s_ex_ctrl), .mem_ctrl(s_mem_ctrl), .wb_ctrl(s_wb_ctrl),
    .id_jump(s_id_jump), .id_illegal(s_id_illegal), .pc_write(s_pc_write),
    .ifid_write(s_ifid_write), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: each instruction is a slot carrying its full control word
  // {ex[3:0], m[2:0], wb[1:0]}; slots move EX -> MEM -> WB one per clock.
  typedef struct {
    logic [8:0] c;
    int         rt;
  } slot_t;

  logic [8:0] dec_tbl [int];
  slot_t      pipe [3];
  int         m_stall = 0;
  int         m_flush = 0;
  bit         pcw_seen, ifw_seen, jump_seen, ill_seen;

  task automatic cyc(input int op, input bit vld, input int rs, input int rt,
                     input bit fl, input bit rst);
    logic [8:0] d;
    bit         jmp, ill, hz, st;
    slot_t      empty;
    @(negedge clk);
    id_opcode = 6'(op);
    id_valid  = vld;
    id_rs     = 5'(rs);
    id_rt     = 5'(rt);
    flush     = fl;
    reset     = rst;
    #1;
    empty = '{c: 9'd0, rt: 0};
    d = 9'd0;
    if (vld && dec_tbl.exists(op)) d = dec_tbl[op];
    jmp = vld && (op == 2);
    ill = vld && !dec_tbl.exists(op) && (op != 2);
    hz  = pipe[0].c[3] && (pipe[0].rt != 0) && ((pipe[0].rt == rs) || (pipe[0].rt == rt));
    st  = hz && !fl && !rst;
    chk("id_jump", id_jump, jmp);
    chk("id_illegal", id_illegal, ill);
    chk("pc_write", pc_write, !rst && !st);
    chk("ifid_write", ifid_write, !rst && !st);
    pcw_seen  = pc_write;
    ifw_seen  = ifid_write;
    jump_seen = id_jump;
    ill_seen  = id_illegal;
    if (rst) begin
      for (int k = 0; k < 3; k++) pipe[k] = empty;
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (hz && !fl) m_stall++;
      if (fl) m_flush++;
      pipe[2] = pipe[1];
      pipe[1] = fl ? empty : pipe[0];
      if (fl || st) pipe[0] = empty;
      else pipe[0] = '{c: d, rt: (vld ? rt : 0)};
    end
    @(posedge clk);
    #1;
    chk("ex_ctrl", ex_ctrl, pipe[0].c[8:5]);
    chk("mem_ctrl", mem_ctrl, pipe[1].c[4:2]);
    chk("wb_ctrl", wb_ctrl, pipe[2].c[1:0]);
    chk("stall_cnt", stall_cnt, (m_stall > 65535) ? 65535 : m_stall);
    chk("flush_cnt", flush_cnt, (m_flush > 65535) ? 65535 : m_flush);
    chk("s_stall_cnt", s_stall_cnt, (m_stall > 3) ? 3 : m_stall);
    chk("s_flush_cnt", s_flush_cnt, (m_flush > 3) ? 3 : m_flush);
  endtask

  int         ops [5]    = '{35, 43, 0, 4, 8};
  logic [3:0] exp_ex [5] = '{4'b0100, 4'b0100, 4'b1010, 4'b0001, 4'b0100};
  logic [1:0] exp_wb [5] = '{2'b11, 2'b00, 2'b10, 2'b00, 2'b10};
  logic [1:0] exp_sat [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
  int         pick [6]   = '{0, 35, 43, 4, 8, 2};

  initial begin
    dec_tbl[0]  = 9'b1010_000_10;
    dec_tbl[35] = 9'b0100_010_11;
    dec_tbl[43] = 9'b0100_001_00;
    dec_tbl[4]  = 9'b0001_100_00;
    dec_tbl[8]  = 9'b0100_000_10;
    for (int k = 0; k < 3; k++) pipe[k] = '{c: 9'd0, rt: 0};

    // Reset state
    cyc(0, 1'b0, 0, 0, 1'b0, 1'b1);
    cyc(0, 1'b0, 0, 0, 1'b0, 1'b1);
    chk("rst_pcw", pcw_seen, 1'b0);
    chk("rst_ex", ex_ctrl, 4'b0000);
    chk("rst_wb", wb_ctrl, 2'b00);
    chk("rst_stall", stall_cnt, 16'd0);

    // lw, sw, R, beq, addi back to back with no dependencies
    for (int i = 0; i < 7; i++) begin
      if (i < 5) cyc(ops[i], 1'b1, 2, (i == 0) ? 1 : 3, 1'b0, 1'b0);
      else cyc(0, 1'b0, 0, 0, 1'b0, 1'b0);
      if (i < 5) chk("seq_ex", ex_ctrl, exp_ex[i]);
      if (i >= 2) chk("seq_wb", wb_ctrl, exp_wb[i-2]);
    end

    // Load-use on rt=5, then the same pair on rt=0
    cyc(35, 1'b1, 0, 5, 1'b0, 1'b0);
    cyc(0, 1'b1, 5, 0, 1'b0, 1'b0);
    chk("lu_pcw", pcw_seen, 1'b0);
    chk("lu_ifw", ifw_seen, 1'b0);
    chk("lu_bubble", ex_ctrl, 4'b0000);
    chk("lu_cnt", stall_cnt, 16'd1);
    cyc(0, 1'b1, 5, 0, 1'b0, 1'b0);
    chk("lu_release", pcw_seen, 1'b1);
    chk("lu_reissue", ex_ctrl, 4'b1010);
    cyc(35, 1'b1, 0, 0, 1'b0, 1'b0);
    cyc(0, 1'b1, 0, 0, 1'b0, 1'b0);
    chk("r0_pcw", pcw_seen, 1'b1);
    chk("r0_cnt", stall_cnt, 16'd1);

    // Flush with beq in EX and lw in ID; older addi keeps flowing to WB
    cyc(8, 1'b1, 0, 0, 1'b0, 1'b0);
    cyc(4, 1'b1, 1, 2, 1'b0, 1'b0);
    cyc(35, 1'b1, 3, 4, 1'b1, 1'b0);
    chk("fl_ex", ex_ctrl, 4'b0000);
    chk("fl_mem", mem_ctrl, 3'b000);
    chk("fl_wb", wb_ctrl, 2'b10);
    chk("fl_cnt", flush_cnt, 16'd1);
    cyc(35, 1'b1, 0, 5, 1'b0, 1'b0);
    cyc(0, 1'b1, 5, 0, 1'b1, 1'b0);
    chk("fl_lu_pcw", pcw_seen, 1'b1);
    chk("fl_lu_stall", stall_cnt, 16'd1);

    // Illegal opcode and jump
    cyc(63, 1'b1, 0, 0, 1'b0, 1'b0);
    chk("ill_flag", ill_seen, 1'b1);
    cyc(2, 1'b1, 0, 0, 1'b0, 1'b0);
    chk("j_flag", jump_seen, 1'b1);
    chk("ill_mem", mem_ctrl, 3'b000);
    cyc(0, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("ill_wb", wb_ctrl, 2'b00);

    // Reset arriving during a stall cycle
    cyc(8, 1'b1, 0, 0, 1'b0, 1'b0);
    cyc(43, 1'b1, 0, 0, 1'b0, 1'b0);
    cyc(35, 1'b1, 0, 5, 1'b0, 1'b0);
    cyc(0, 1'b1, 5, 0, 1'b0, 1'b1);
    chk("rs_pcw", pcw_seen, 1'b0);
    chk("rs_ex", ex_ctrl, 4'b0000);
    chk("rs_mem", mem_ctrl, 3'b000);
    chk("rs_wb", wb_ctrl, 2'b00);
    chk("rs_stall", stall_cnt, 16'd0);
    chk("rs_flush", flush_cnt, 16'd0);
    cyc(0, 1'b1, 5, 0, 1'b0, 1'b0);
    chk("rs_after", ex_ctrl, 4'b1010);

    // 2-bit flush counter saturates
    cyc(0, 1'b0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1'b1, 0, 0, 1'b1, 1'b0);
      chk("sat_flush", s_flush_cnt, exp_sat[i]);
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int r, op;
      r  = $urandom_range(0, 7);
      op = (r < 6) ? pick[r] : int'($urandom_range(0, 63));
      cyc(op, $urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_control_unit.md
Name: pipe_control_unit

Overview:
- Parametrised pipelined successor to the combinational MIPS main decoder.
- Decodes the ID-stage opcode into EX/M/WB control bundles and carries them through ID/EX, EX/MEM and MEM/WB control registers.
- Adds addi and j decode, an illegal-opcode flag, load-use hazard detection with bubble insertion, branch/jump flush, and saturating stall/flush counters.
- Sits beside the datapath pipeline registers; the datapath consumes the staged control outputs.

Parameters:
- OPCODE_W, 6, opcode width.
- REG_W, 5, register-address width.
- CNT_W, 16, width of the stall/flush event counters.
- EN_HAZARD, 1, 1 = load-use detection active; 0 = stall never asserted.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous active-high reset.
- id_opcode  in  OPCODE_W  opcode of the instruction in ID.
- id_valid  in  1  ID holds a real instruction; 0 = decode as bubble.
- id_rs  in  REG_W  rs field of the instruction in ID.
- id_rt  in  REG_W  rt field of the instruction in ID.
- flush  in  1  branch/jump taken; kill the instructions in ID and EX.
- ex_ctrl  out  4  ID/EX register: [3] RegDst, [2] ALUSrc, [1:0] ALUOp.
- mem_ctrl  out  3  EX/MEM register: [2] Branch, [1] MemRead, [0] MemWrite.
- wb_ctrl  out  2  MEM/WB register: [1] RegWrite, [0] MemToReg.
- id_jump  out  1  combinational; ID holds j (opcode 2) and id_valid=1.
- id_illegal  out  1  combinational; id_valid=1 and opcode not decoded.
- pc_write  out  1  combinational; PC update enable.
- ifid_write  out  1  combinational; IF/ID register write enable.
- stall_cnt  out  CNT_W  saturating count of stall cycles.
- flush_cnt  out  CNT_W  saturating count of flush cycles.

Behaviour:
- Decode table, {ex, m, wb}, combinational in ID:
  - 0 (R-type): 1010, 000, 10
  - 35 (lw): 0100, 010, 11
  - 43 (sw): 0100, 001, 00
  - 4 (beq): 0001, 100, 00. RegWrite is 0 for beq; the old unit's RegWrite=1 is fixed.
  - 8 (addi): 0100, 000, 10
  - 2 (j): all zero, id_jump=1
  - anything else: all zero, id_illegal=1
- id_valid=0: all decode outputs zero and id_illegal=0.
- Pipeline movement, each clk:
  - ID/EX captures {ex, m, wb, id_rt}.
  - EX/MEM captures ID/EX.{m, wb}.
  - MEM/WB captures EX/MEM.wb.
- Output latency: ex_ctrl is valid 1 cycle after decode, mem_ctrl after 2 cycles, wb_ctrl after 3 cycles.
- Load-use stall:
  - Condition: EN_HAZARD and ID/EX.MemRead and ID/EX.rt != 0 and (ID/EX.rt == id_rs or ID/EX.rt == id_rt).
  - While stalled: pc_write=0, ifid_write=0, ID/EX loads all-zero bubble; EX/MEM and MEM/WB advance normally.
  - A stall lasts exactly 1 cycle, because the bubble clears MemRead.
- Flush:
  - ID/EX and EX/MEM load zero next edge; MEM/WB advances.
  - Flush has priority over stall: during flush, stall is suppressed and pc_write=ifid_write=1.
- Counters:
  - stall_cnt +1 per cycle with the stall condition true and no flush.
  - flush_cnt +1 per cycle with flush=1.
  - Both saturate at all-ones; no wrap.
- Reset (synchronous, overrides all):
  - All control registers, stored rt and counters go to 0.
  - During reset: pc_write=0, ifid_write=0, no counting.
  - Reset mid-stall or mid-flush discards the event.
  - First edge after reset release behaves as normal.
- id_rt of a bubbled or flushed slot is stored as 0, so no false hazard follows.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - opcode constants: OP_RTYPE=0, OP_J=2, OP_BEQ=4, OP_ADDI=8, OP_LW=35, OP_SW=43
  - bundle widths: EX_W=4, M_W=3, WB_W=2
  - field bit indices and ALUOp encodings (00 add, 01 sub, 10 funct)
- One sub-module: pipe_ctrl_decode, a pure combinational table producing {ex, m, wb, jump, illegal}. Pipeline registers, hazard logic and counters stay in pipe_control_unit.

Test Plan:
- Reset, then lw (35), sw (43), R (0), beq (4), addi (8) on consecutive cycles, no hazards:
  - ex_ctrl sequence 0100, 0100, 1010, 0001, 0100.
  - wb_ctrl shows 11, 00, 10, 00, 10 three cycles after each decode.
- lw with rt=5, then R-type with rs=5:
  - 1 cycle of pc_write=0, ifid_write=0; ex_ctrl=0000 bubble; stall_cnt=1.
  - Repeat with rt=0: no stall.
- Flush asserted while beq is in EX and a lw is in ID:
  - next cycle ex_ctrl=0000 and mem_ctrl=000; wb_ctrl of the older instruction is unchanged; flush_cnt=1.
  - Flush coincident with a load-use condition: pc_write=1, stall_cnt unchanged.
- Opcode 63 with id_valid=1: id_illegal=1, all controls zero downstream. Opcode 2: id_jump=1.
- Reset asserted mid-stall with valid controls in all stages:
  - next edge all outputs and counters 0; pc_write=0 while reset is high.
- CNT_W=2, flush held 6 cycles: flush_cnt 1, 2, 3, 3, 3, 3 (saturates, no wrap).
